// File: rtl/mem_bus_controller_pkg.sv
// Shared constants for the memory bus controller: FSM states, byte-enable codes, request encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_bus_controller_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        MBC_STATE_IDLE   = 2'd0,
        MBC_STATE_SETUP  = 2'd1,
        MBC_STATE_STROBE = 2'd2,
        MBC_STATE_DONE   = 2'd3
    } mbc_state_e;

    // MEM_BE codes, bit0 = lane [7:0]
    localparam logic [1:0] BE_NONE = 2'b00;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_BOTH = 2'b11;

    // Request strobe encodings shared with the instruction-group control mux
    localparam logic RDX_READ   = 1'b1;
    localparam logic WRX_WRITE  = 1'b1;
    localparam logic BYTEX_BYTE = 1'b1;
    localparam logic BYTEX_WORD = 1'b0;

    // Word accesses ignore address bit 0 (odd addresses are aligned down)
    function automatic logic [15:0] mbc_align_word(input logic [15:0] addr);
        return {addr[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/mem_bus_controller_if.sv
// Request/response and external memory signals of the bus controller, grouped in one bundle.
// Latency: n/a (wiring only).
// Backpressure: busy from the slave stalls the master; mem_ready stretches the strobe.
interface mem_bus_controller_if;
    logic        start;
    logic        rdx;
    logic        wrx;
    logic        bytex;
    logic [15:0] addr_in;
    logic [15:0] wdata;
    logic [15:0] mem_din;
    logic        mem_ready;
    logic [15:0] mem_addr;
    logic [15:0] mem_dout;
    logic [1:0]  mem_be;
    logic        mem_rd_n;
    logic        mem_wr_n;
    logic        busy;
    logic [15:0] rdata;
    logic        rdata_valid;
    logic        bus_err;

    // Sequencer plus external memory side
    modport master (
        output start, rdx, wrx, bytex, addr_in, wdata, mem_din, mem_ready,
        input  mem_addr, mem_dout, mem_be, mem_rd_n, mem_wr_n, busy, rdata, rdata_valid, bus_err
    );

    // Controller side
    modport slave (
        input  start, rdx, wrx, bytex, addr_in, wdata, mem_din, mem_ready,
        output mem_addr, mem_dout, mem_be, mem_rd_n, mem_wr_n, busy, rdata, rdata_valid, bus_err
    );
endinterface

// File: rtl/mem_byte_lane.sv
// Little-endian byte-lane steering: write BE/data replication and read lane select with zero extend.
// Latency: combinational.
// Backpressure: none.
module mem_byte_lane
    import mem_bus_controller_pkg::*;
(
    input  logic        wr_bytex_i,
    input  logic        wr_addr0_i,
    input  logic [15:0] wdata_i,
    output logic [1:0]  be_o,
    output logic [15:0] dout_o,
    input  logic        rd_bytex_i,
    input  logic        rd_addr0_i,
    input  logic [15:0] mem_din_i,
    output logic [15:0] rdata_o
);

    // Write path: a byte is replicated on both lanes so the BE alone picks the target byte
    always_comb begin
        be_o   = BE_BOTH;
        dout_o = wdata_i;
        if (wr_bytex_i != BYTEX_WORD) begin
            be_o   = wr_addr0_i ? BE_HI : BE_LO;
            dout_o = {wdata_i[7:0], wdata_i[7:0]};
        end
    end

    // Read path: select the addressed lane and zero-extend it for byte reads
    always_comb begin
        rdata_o = mem_din_i;
        if (rd_bytex_i == BYTEX_BYTE) begin
            rdata_o = rd_addr0_i ? {8'h00, mem_din_i[15:8]} : {8'h00, mem_din_i[7:0]};
        end
    end

endmodule

// File: rtl/mem_bus_controller.sv
// Sequences one accepted RDX/WRX request into setup, strobe, wait-for-ready and done phases.
// Latency: accept edge + SETUP_CYCLES + strobe cycles; read data valid one cycle after ready (min 3 edges).
// Backpressure: BUSY stalls the sequencer until DONE; MEM_READY low stretches STROBE (optional abort: MEM_BUS_TIMEOUT_EN).
module mem_bus_controller
    import mem_bus_controller_pkg::*;
#(
    parameter int SETUP_CYCLES   = 1,    // legal 1..4
    parameter int TIMEOUT_CYCLES = 255   // only used with MEM_BUS_TIMEOUT_EN
) (
    input  logic              CLK,
    input  logic              RESET_N,
    mem_bus_controller_if.slave bus
);

    localparam logic [2:0] SETUP_LAST = 3'(SETUP_CYCLES - 1);

    mbc_state_e  state_q;
    logic [2:0]  setup_cnt_q;
    logic        is_wr_q;
    logic        bytex_q;
    logic [15:0] mem_addr_q;
    logic [15:0] mem_dout_q;
    logic [1:0]  mem_be_q;
    logic        mem_rd_n_q;
    logic        mem_wr_n_q;
    logic        busy_q;
    logic [15:0] rdata_q;
    logic        rdata_valid_q;
    logic        bus_err_q;

    logic        req_rd;
    logic        req_wr;
    logic [1:0]  be_d;
    logic [15:0] dout_d;
    logic [15:0] rd_lane_d;

    // A write strobe wins when both request strobes are set
    assign req_rd = (bus.rdx == RDX_READ);
    assign req_wr = (bus.wrx == WRX_WRITE);

    mem_byte_lane u_lane (
        .wr_bytex_i (bus.bytex),
        .wr_addr0_i (bus.addr_in[0]),
        .wdata_i    (bus.wdata),
        .be_o       (be_d),
        .dout_o     (dout_d),
        .rd_bytex_i (bytex_q),
        .rd_addr0_i (mem_addr_q[0]),
        .mem_din_i  (bus.mem_din),
        .rdata_o    (rd_lane_d)
    );

`ifdef MEM_BUS_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_cnt_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // Access sequencer with all bus-facing outputs registered
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= MBC_STATE_IDLE;
            setup_cnt_q   <= '0;
            is_wr_q       <= 1'b0;
            bytex_q       <= 1'b0;
            mem_addr_q    <= '0;
            mem_dout_q    <= '0;
            mem_be_q      <= BE_NONE;
            mem_rd_n_q    <= 1'b1;
            mem_wr_n_q    <= 1'b1;
            busy_q        <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            bus_err_q     <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
            to_cnt_q      <= '0;
`endif
        end else begin
            rdata_valid_q <= 1'b0;
            case (state_q)
                MBC_STATE_IDLE: begin
                    if (bus.start && (req_rd || req_wr)) begin
                        is_wr_q     <= req_wr;
                        bytex_q     <= bus.bytex;
                        mem_addr_q  <= (bus.bytex == BYTEX_BYTE) ? bus.addr_in
                                                                 : mbc_align_word(bus.addr_in);
                        mem_be_q    <= be_d;
                        mem_dout_q  <= dout_d;
                        busy_q      <= 1'b1;
                        setup_cnt_q <= '0;
                        state_q     <= MBC_STATE_SETUP;
                    end
                end
                MBC_STATE_SETUP: begin
                    if (setup_cnt_q == SETUP_LAST) begin
                        setup_cnt_q <= '0;
                        mem_rd_n_q  <= is_wr_q;
                        mem_wr_n_q  <= !is_wr_q;
`ifdef MEM_BUS_TIMEOUT_EN
                        to_cnt_q    <= '0;
`endif
                        state_q     <= MBC_STATE_STROBE;
                    end else begin
                        setup_cnt_q <= setup_cnt_q + 3'd1;
                    end
                end
                MBC_STATE_STROBE: begin
                    if (bus.mem_ready) begin
                        mem_rd_n_q <= 1'b1;
                        mem_wr_n_q <= 1'b1;
                        busy_q     <= 1'b0;
                        if (!is_wr_q) begin
                            rdata_q       <= rd_lane_d;
                            rdata_valid_q <= 1'b1;
                        end
                        state_q    <= MBC_STATE_DONE;
                    end
`ifdef MEM_BUS_TIMEOUT_EN
                    else if (to_cnt_q == TIMEOUT_LAST) begin
                        // Abort: reads return all-ones and the error stays flagged until reset
                        mem_rd_n_q <= 1'b1;
                        mem_wr_n_q <= 1'b1;
                        busy_q     <= 1'b0;
                        bus_err_q  <= 1'b1;
                        if (!is_wr_q) begin
                            rdata_q       <= 16'hFFFF;
                            rdata_valid_q <= 1'b1;
                        end
                        state_q    <= MBC_STATE_DONE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 16'd1;
                    end
`endif
                end
                MBC_STATE_DONE: begin
                    // IDLE must be visited before the next request can be accepted
                    state_q <= MBC_STATE_IDLE;
                end
                default: state_q <= MBC_STATE_IDLE;
            endcase
        end
    end

    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_dout    = mem_dout_q;
    assign bus.mem_be      = mem_be_q;
    assign bus.mem_rd_n    = mem_rd_n_q;
    assign bus.mem_wr_n    = mem_wr_n_q;
    assign bus.busy        = busy_q;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.bus_err     = bus_err_q;

endmodule

// File: tb/tb_mem_bus_controller.sv
// Self-checking bench for mem_bus_controller: directed table, corner sequences, random vs. reference model.
// Latency: n/a.
// Backpressure: bench models memory ready delay per transaction.
module tb_mem_bus_controller;

    localparam int SETUP_N = 1;
    localparam int TO_N    = 4;

    logic CLK     = 1'b0;
    logic RESET_N = 1'b0;

    mem_bus_controller_if bus();

    mem_bus_controller #(
        .SETUP_CYCLES   (SETUP_N),
        .TIMEOUT_CYCLES (TO_N)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        byt;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] din;
        int          delay;     // STROBE edges with ready low before it rises
        int          exp_strb;  // expected strobe-low cycles
        logic [15:0] e_addr;
        logic [1:0]  e_be;
        logic [15:0] e_dout;
        logic [15:0] e_rdata;   // RDATA after the access
        logic        e_valid;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] mdl_rdata = 16'h0000;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic byt,
                                input logic [15:0] addr, input logic [15:0] wdata,
                                input logic [15:0] din, input int delay,
                                input logic [15:0] e_addr, input logic [1:0] e_be,
                                input logic [15:0] e_dout, input logic [15:0] e_rdata,
                                input logic e_valid);
        vec_t v;
        v.rd = rd; v.wr = wr; v.byt = byt; v.addr = addr; v.wdata = wdata; v.din = din;
        v.delay = delay; v.exp_strb = delay + 1;
        v.e_addr = e_addr; v.e_be = e_be; v.e_dout = e_dout; v.e_rdata = e_rdata; v.e_valid = e_valid;
        return v;
    endfunction

    // Reference model: expected bus image and result from the access rules
    function automatic vec_t model(input vec_t v, input logic [15:0] prev_rdata);
        vec_t r = v;
        int   a = int'(v.addr);
        int   w = int'(v.wdata);
        int   d = int'(v.din);
        int   lane;
        if (v.byt) begin
            r.e_addr = v.addr;
            r.e_be   = (a % 2 == 1) ? 2'b10 : 2'b01;
            r.e_dout = 16'((w % 256) * 257);
            lane     = (a % 2 == 1) ? (d / 256) : (d % 256);
        end else begin
            r.e_addr = 16'(a - (a % 2));
            r.e_be   = 2'b11;
            r.e_dout = v.wdata;
            lane     = d;
        end
        r.e_valid  = !v.wr;
        r.e_rdata  = v.wr ? prev_rdata : 16'(lane);
        r.exp_strb = v.delay + 1;
        return r;
    endfunction

    // One complete access from request to the IDLE cycle after DONE
    task automatic run_txn(input vec_t v, input string nm);
        int   busy_c = 0, rd_c = 0, wr_c = 0, vld_c = 0, cyc = 0;
        bit   done = 0, moved = 0;
        logic is_rd = v.rd && !v.wr;
        bus.start = 1'b1; bus.rdx = v.rd; bus.wrx = v.wr; bus.bytex = v.byt;
        bus.addr_in = v.addr; bus.wdata = v.wdata; bus.mem_din = v.din; bus.mem_ready = 1'b0;
        @(posedge CLK); #1;
        // Requests are ignored while busy: scramble them to prove it
        bus.start = 1'b0; bus.addr_in = ~v.addr; bus.wdata = ~v.wdata; bus.bytex = ~v.byt;
        check({nm, " accept_busy"}, 32'(bus.busy), 32'd1);
        check({nm, " mem_addr"}, 32'(bus.mem_addr), 32'(v.e_addr));
        check({nm, " mem_be"}, 32'(bus.mem_be), 32'(v.e_be));
        check({nm, " mem_dout"}, 32'(bus.mem_dout), 32'(v.e_dout));
        while (!done && cyc < 200) begin
            if (bus.busy) busy_c++;
            if (!bus.mem_rd_n) rd_c++;
            if (!bus.mem_wr_n) wr_c++;
            if (bus.rdata_valid) vld_c++;
            if (bus.mem_addr !== v.e_addr || bus.mem_be !== v.e_be || bus.mem_dout !== v.e_dout) moved = 1;
            bus.mem_ready = ((rd_c + wr_c) > v.delay);
            @(posedge CLK); #1;
            cyc++;
            if (!bus.busy) done = 1;
        end
        check({nm, " done_within_budget"}, 32'(done), 32'd1);
        check({nm, " busy_cycles"}, 32'(busy_c), 32'(SETUP_N + v.exp_strb));
        check({nm, " rd_strobe_cycles"}, 32'(rd_c), is_rd ? 32'(v.exp_strb) : 32'd0);
        check({nm, " wr_strobe_cycles"}, 32'(wr_c), is_rd ? 32'd0 : 32'(v.exp_strb));
        check({nm, " bus_stable"}, 32'(moved), 32'd0);
        check({nm, " strobes_high_at_done"}, {30'd0, bus.mem_rd_n, bus.mem_wr_n}, 32'd3);
        check({nm, " early_valid"}, 32'(vld_c), 32'd0);
        check({nm, " valid_at_done"}, 32'(bus.rdata_valid), 32'(v.e_valid));
        check({nm, " rdata"}, 32'(bus.rdata), 32'(v.e_rdata));
        bus.mem_ready = 1'b0;
        @(posedge CLK); #1;
        check({nm, " valid_single_pulse"}, 32'(bus.rdata_valid), 32'd0);
        check({nm, " idle_not_busy"}, 32'(bus.busy), 32'd0);
        mdl_rdata = v.e_rdata;
    endtask

    // Wait (bounded) for the controller to drain back to IDLE
    task automatic wait_idle(input string nm);
        int cyc = 0;
        bus.mem_ready = 1'b1;
        while (bus.busy && cyc < 50) begin
            @(posedge CLK); #1;
            cyc++;
        end
        check({nm, " drain_budget"}, 32'(bus.busy), 32'd0);
        bus.mem_ready = 1'b0;
        @(posedge CLK); #1;
    endtask

    vec_t tbl[8];
    vec_t rv;
    int   w_c, r_c;

    initial begin
        bus.start = 0; bus.rdx = 0; bus.wrx = 0; bus.bytex = 0;
        bus.addr_in = '0; bus.wdata = '0; bus.mem_din = '0; bus.mem_ready = 0;

        // Directed vectors: rd, wr, byte, addr, wdata, din, delay, exp addr/be/dout/rdata/valid
        tbl[0] = mk(1, 0, 0, 16'h1235, 16'h0000, 16'hBEEF, 0, 16'h1234, 2'b11, 16'h0000, 16'hBEEF, 1);
        tbl[1] = mk(0, 1, 1, 16'h0041, 16'h00A5, 16'h0000, 0, 16'h0041, 2'b10, 16'hA5A5, 16'hBEEF, 0);
        tbl[2] = mk(1, 0, 1, 16'h0040, 16'h0000, 16'h12F0, 3, 16'h0040, 2'b01, 16'h0000, 16'h00F0, 1);
        tbl[3] = mk(1, 0, 1, 16'h0041, 16'h0000, 16'h12F0, 3, 16'h0041, 2'b10, 16'h0000, 16'h0012, 1);
        tbl[4] = mk(0, 1, 0, 16'h8001, 16'h1357, 16'hFFFF, 1, 16'h8000, 2'b11, 16'h1357, 16'h0012, 0);
        tbl[5] = mk(1, 1, 1, 16'h0002, 16'h34CC, 16'h5555, 2, 16'h0002, 2'b01, 16'hCCCC, 16'h0012, 0);
        tbl[6] = mk(1, 0, 0, 16'hFFFF, 16'hAAAA, 16'h0F0F, 0, 16'hFFFE, 2'b11, 16'hAAAA, 16'h0F0F, 1);
        tbl[7] = mk(1, 0, 1, 16'hFFFF, 16'h0000, 16'h80C3, 2, 16'hFFFF, 2'b10, 16'h0000, 16'h0080, 1);

        // Reset values
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("reset mem_addr", 32'(bus.mem_addr), 32'h0);
        check("reset mem_dout", 32'(bus.mem_dout), 32'h0);
        check("reset mem_be", 32'(bus.mem_be), 32'h0);
        check("reset strobes", {30'd0, bus.mem_rd_n, bus.mem_wr_n}, 32'd3);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset rdata", 32'(bus.rdata), 32'h0);
        check("reset rdata_valid", 32'(bus.rdata_valid), 32'd0);
        check("reset bus_err", 32'(bus.bus_err), 32'd0);
        RESET_N = 1'b1;
        @(posedge CLK); #1;

        // START without RDX/WRX is ignored
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            check("no_strobe busy", 32'(bus.busy), 32'd0);
            check("no_strobe strobes", {30'd0, bus.mem_rd_n, bus.mem_wr_n}, 32'd3);
        end
        bus.start = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i], $sformatf("tbl%0d", i));
        end

        // RDX=WRX with START held through the access: one write, next accept only after DONE+IDLE
        bus.start = 1'b1; bus.rdx = 1'b1; bus.wrx = 1'b1; bus.bytex = 1'b0;
        bus.addr_in = 16'h0300; bus.wdata = 16'h1111; bus.mem_ready = 1'b1;
        @(posedge CLK); #1;
        check("hold accept_busy", 32'(bus.busy), 32'd1);
        check("hold first_addr", 32'(bus.mem_addr), 32'h0300);
        bus.addr_in = 16'h2222;
        w_c = 0; r_c = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            if (!bus.mem_wr_n) w_c++;
            if (!bus.mem_rd_n) r_c++;
        end
        check("hold single_write", 32'(w_c), 32'd1);
        check("hold no_read", 32'(r_c), 32'd0);
        check("hold not_busy_in_idle", 32'(bus.busy), 32'd0);
        check("hold addr_kept", 32'(bus.mem_addr), 32'h0300);
        @(posedge CLK); #1;
        check("hold second_accept", 32'(bus.busy), 32'd1);
        check("hold second_addr", 32'(bus.mem_addr), 32'h2222);
        bus.start = 1'b0; bus.rdx = 1'b0; bus.wrx = 1'b0;
        wait_idle("hold");

        // Reset in the second STROBE cycle of a write
        bus.start = 1'b1; bus.rdx = 1'b0; bus.wrx = 1'b1; bus.bytex = 1'b0;
        bus.addr_in = 16'h0100; bus.wdata = 16'h5A5A; bus.mem_ready = 1'b0;
        @(posedge CLK); #1;
        bus.start = 1'b0; bus.wrx = 1'b0;
        @(posedge CLK); #1;
        check("rst_mid first_strobe", 32'(bus.mem_wr_n), 32'd0);
        @(posedge CLK); #1;
        check("rst_mid second_strobe", 32'(bus.mem_wr_n), 32'd0);
        RESET_N = 1'b0;
        #1;
        check("rst_mid wr_n", 32'(bus.mem_wr_n), 32'd1);
        check("rst_mid busy", 32'(bus.busy), 32'd0);
        check("rst_mid addr", 32'(bus.mem_addr), 32'h0);
        check("rst_mid rdata", 32'(bus.rdata), 32'h0);
        #1;
        RESET_N = 1'b1;
        bus.mem_ready = 1'b1;
        r_c = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            if (bus.rdata_valid || bus.busy || !bus.mem_wr_n) r_c++;
        end
        check("rst_mid quiet_after", 32'(r_c), 32'd0);
        bus.mem_ready = 1'b0;
        mdl_rdata = 16'h0000;

`ifdef MEM_BUS_TIMEOUT_EN
        // READY stuck low: abort after TO_N strobe cycles with all-ones read data
        rv = mk(1, 0, 0, 16'h0010, 16'h0000, 16'h1234, 1000, 16'h0010, 2'b11, 16'h0000, 16'hFFFF, 1);
        rv.exp_strb = TO_N;
        run_txn(rv, "timeout");
        check("timeout bus_err", 32'(bus.bus_err), 32'd1);
`else
        // Without the timeout feature a long stall simply completes
        rv = mk(1, 0, 0, 16'h0020, 16'h0000, 16'h4321, 9, 16'h0020, 2'b11, 16'h0000, 16'h4321, 1);
        run_txn(rv, "long_stall");
`endif

        // Random accesses checked against the reference model
        for (int i = 0; i < 40; i++) begin
            int sel;
            sel      = int'($urandom_range(1, 3));
            rv.rd    = (sel % 2) == 1;
            rv.wr    = sel >= 2;
            rv.byt   = 1'($urandom_range(0, 1));
            rv.addr  = 16'($urandom);
            rv.wdata = 16'($urandom);
            rv.din   = 16'($urandom);
            rv.delay = int'($urandom_range(0, 3));
            rv = model(rv, mdl_rdata);
            run_txn(rv, $sformatf("rnd%0d", i));
        end

`ifdef MEM_BUS_TIMEOUT_EN
        check("final bus_err sticky", 32'(bus.bus_err), 32'd1);
`else
        check("final bus_err tied", 32'(bus.bus_err), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_controller.md
Name: mem_bus_controller

Overview:
- Memory-side responder for the per-group control strobes produced by the instruction-group control multiplexer (RDX, WRX, BYTEX, selected address and data bus).
- Turns one accepted request into a sequenced external memory cycle: setup, strobe, wait-for-ready, completion.
- Performs little-endian byte-lane steering and stalls the core sequencer through BUSY until the access completes.

Parameters:
- SETUP_CYCLES, 1, cycles the address/BE/write data are held before the strobe asserts (legal 1..4).
- TIMEOUT_CYCLES, 255, STROBE cycles without MEM_READY before abort (only with MEM_BUS_TIMEOUT_EN).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- START  in  1  request qualifier (EXECUTE phase); sampled only in IDLE.
- RDX  in  1  read request (RDX constant encoding).
- WRX  in  1  write request (WRX constant encoding).
- BYTEX  in  1  1 = byte access, 0 = word access.
- ADDR_IN  in  16  address selected by ADDR_BUSX.
- WDATA  in  16  write data selected by DATA_BUSX; byte writes use [7:0].
- MEM_DIN  in  16  external read data.
- MEM_READY  in  1  external access complete, sampled in STROBE.
- MEM_ADDR  out  16  external address.
- MEM_DOUT  out  16  external write data.
- MEM_BE  out  2  byte enables, bit0 = lane [7:0].
- MEM_RD_N  out  1  active-low read strobe.
- MEM_WR_N  out  1  active-low write strobe.
- BUSY  out  1  stall to sequencer.
- RDATA  out  16  read result.
- RDATA_VALID  out  1  one-cycle pulse when RDATA is updated.
- BUS_ERR  out  1  sticky timeout flag (tied 0 without the feature).

Behaviour:
- Reset values: async on RESET_N low, regardless of state.
  - MEM_ADDR = 0, MEM_DOUT = 0, MEM_BE = 00.
  - MEM_RD_N = 1, MEM_WR_N = 1.
  - BUSY = 0, RDATA = 0, RDATA_VALID = 0, BUS_ERR = 0.
  - State = IDLE, counters = 0.
- Reset mid-access: strobes deassert immediately; no RDATA_VALID pulse.
- States: IDLE, SETUP, STROBE, DONE; all outputs registered.
- IDLE:
  - START & (RDX | WRX) at an edge: latch the request, go to SETUP, set BUSY.
  - START with neither strobe set: ignored.
  - RDX & WRX together: treated as a write.
- Address and lane steering, applied on the accept edge:
  - Word access: MEM_ADDR = {ADDR_IN[15:1], 0}, BE = 11, MEM_DOUT = WDATA. An odd address is silently aligned down.
  - Byte access: MEM_ADDR = ADDR_IN, BE = 01 for even address, 10 for odd. MEM_DOUT = {WDATA[7:0], WDATA[7:0]}.
- SETUP: counts SETUP_CYCLES, then goes to STROBE with MEM_RD_N or MEM_WR_N driven low.
- STROBE:
  - MEM_READY = 1 at an edge: capture read data, go to DONE, strobe returns high.
  - Read data: word → RDATA = MEM_DIN; byte → RDATA = {8'h00, selected lane}, zero-extended.
  - MEM_READY low: hold all outputs stable.
- DONE (one cycle): RDATA_VALID = 1 for reads only; BUSY = 0 from this cycle on; next state IDLE.
- Back-to-back requests: the earliest new accept is the edge after DONE (IDLE must be visited).
- Minimum latency, SETUP_CYCLES = 1 and READY already high: accept at edge 0, STROBE low after edge 1, DONE after edge 2, RDATA_VALID high in cycle 2→3.
- Request inputs are ignored while BUSY; the sequencer holds them stable.

Optional Feature:
- Macro: MEM_BUS_TIMEOUT_EN.
- Defined:
  - STROBE counts cycles without MEM_READY.
  - When the count reaches TIMEOUT_CYCLES, the strobe deasserts and the block goes to DONE.
  - Reads: RDATA = 16'hFFFF with RDATA_VALID pulsed.
  - BUS_ERR sets and stays set until reset.
- Undefined: no counter; STROBE waits for MEM_READY indefinitely; BUS_ERR tied 0.

Decomposition:
- Shared constants file gets:
  - state encodings (MBC_STATE_IDLE/SETUP/STROBE/DONE);
  - MEM_BE codes (BE_NONE/LO/HI/BOTH);
  - the existing RDX/WRX/BYTEX encodings, reused as-is.
- One sub-module: mem_byte_lane, combinational.
  - Write path: address + BYTEX + WDATA → BE and MEM_DOUT.
  - Read path: MEM_DIN + latched address bit 0 + BYTEX → RDATA.

Test Plan:
- Word read at 0x1235, MEM_DIN = 0xBEEF, READY held high → MEM_ADDR = 0x1234, BE = 11, MEM_RD_N low for exactly 1 cycle, RDATA = 0xBEEF, VALID pulse at cycle 3.
- Byte write at 0x0041, WDATA = 0x00A5 → MEM_ADDR = 0x0041, BE = 10, MEM_DOUT = 0xA5A5, MEM_WR_N low, no VALID pulse, BUSY 2 cycles.
- Byte read at 0x0040 and at 0x0041, MEM_DIN = 0x12F0, READY delayed 3 cycles → RDATA = 0x00F0 then 0x0012; strobe low 4 cycles each; BUSY held throughout.
- RESET_N low in the second STROBE cycle of a write → MEM_WR_N = 1 immediately, BUSY = 0, state IDLE, no VALID.
- RDX = WRX = 1 with START, then a new START during BUSY → single write cycle; second request ignored; next accept only after DONE.
- MEM_BUS_TIMEOUT_EN, TIMEOUT_CYCLES = 4, READY stuck low on a read → abort after 4 STROBE cycles, RDATA = 0xFFFF, BUS_ERR = 1 sticky.
